seq_multiplier_n: RTL and testbench
===================================

# seq_multiplier_n

Parametrised iterative shift-add multiplier with unsigned/signed mode, early termination and a built-in sequential binary-to-BCD converter. Sits between operand switches and the `scan`/`p7seg` display path. Replaces the fixed 8-bit multiplier: start/done handshake, no separate load strobes, and the product is already in BCD for display.

## Interface
Parameters:
- `WIDTH`, 8: operand width in bits; the product is 2·WIDTH bits.
- `DIGITS`, (2·WIDTH·301)/1000+1 (local, derived): number of BCD digits. Value is 5 for WIDTH=8.

Ports:
- `clk`, in, 1: single clock; every register is clocked on its rising edge.
- `clrn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request. Sampled only in IDLE.
- `sign_mode`, in, 1: 0 = unsigned, 1 = two's-complement. Sampled with `start`.
- `a`, in, WIDTH: multiplicand, sampled with `start`.
- `b`, in, WIDTH: multiplier, sampled with `start`.
- `busy`, out, 1: high from the edge after `start` is accepted until the operation completes.
- `done`, out, 1: one-cycle pulse when the results update.
- `p`, out, 2·WIDTH: product, two's-complement in signed mode. Held until the next completion.
- `p_neg`, out, 1: product is negative (signed mode only).
- `p_bcd`, out, 4·DIGITS: BCD of |p|, least significant digit in [3:0]. Held.

## Operation
- Reset: `busy`, `done`, `p`, `p_neg`, `p_bcd` and all internal registers go to 0; state goes to IDLE. Reset during MUL or BCD aborts the operation. No partial result is ever published.
- State machine has three states: IDLE, MUL and BCD.
- IDLE, with `start`=1: capture the operands.
  - `ma` = |a| zero-extended to 2·WIDTH; `mb` = |b|; `acc` = 0.
  - `neg` = sign_mode & (a[msb] ^ b[msb]).
  - Unsigned mode: the magnitude is the raw value.
  - Go to MUL; `busy` becomes 1.
- MUL, one step per cycle:
  - If `mb[0]` is set, `acc` += `ma`.
  - Shift `ma` left by 1; shift `mb` right by 1.
  - When (mb>>1)==0, leave for BCD at the next edge with `acc` final.
  - The final value is negated when `neg` is set.
  - Minimum is 1 cycle, including b=0.
- BCD: double-dabble over the 2·WIDTH-bit magnitude `acc`, exactly 2·WIDTH cycles. Each cycle: add 3 to every digit ≥5, then shift left by one bit.
  - At the last BCD edge, register `p`, `p_neg` and `p_bcd`, pulse `done`, drop `busy`, and return to IDLE.
- `start` while `busy`=1 is ignored; there is no queueing.
- `start` held high causes back-to-back operations: IDLE accepts it on the edge after `done`.
- Magnitude rule: |−2^(WIDTH−1)| = 2^(WIDTH−1) fits in WIDTH unsigned bits. The product magnitude is at most 2^(2·WIDTH−2) in signed mode, so there is no overflow in either mode.

## Timing
- Let `start` be accepted at edge 0. Let k = max(1, position of the highest set bit of |b| + 1).
- MUL occupies edges 1..k and BCD occupies edges k+1..k+2·WIDTH.
- `done`=1 and the new results are visible after edge k+2·WIDTH, for exactly one cycle. Worst case is 3·WIDTH+1 cycles.
- `busy` is 1 after edges 0 through k+2·WIDTH−1 and 0 after edge k+2·WIDTH.
- Outputs change only at completion or on reset. Between operations they are stable, which suits the slow `scan` clock domain.

## Structure
- Shared include `mult_pkg.vh`:
  - State encodings: IDLE=2'd0, MUL=2'd1, BCD=2'd2.
  - The DIGITS formula, shared with `scan` and a future wide-display scanner.
- Sub-module `bin2bcd_seq #(BITS, DIGITS)`: ports `clk`, `clrn`, `load`, `bin`, `busy`, `bcd`, `valid`.
  - Holds the double-dabble shift register and counter.
  - The top FSM asserts `load` on MUL exit and treats `valid` as BCD completion.
- The top module holds the operand and accumulator registers, sign handling and the output registers.

## Test plan
- WIDTH=8, unsigned, a=12, b=13, single `start` pulse:
  - `p`=156, `p_bcd`=20'h00156, `p_neg`=0.
  - `done` is high after edge 20 only (k=4); `busy` is high after edges 0–19.
- Unsigned a=255, b=255: `p`=65025, `p_bcd`=20'h65025, `done` after edge 24. Also a=200, b=0: `p`=0, `p_bcd`=0, `done` after edge 17 (k=1).
- Signed mode:
  - a=−3 (8'hFD), b=5: `p`=16'hFFF1, `p_neg`=1, `p_bcd`=20'h00015.
  - a=b=−128: `p`=16384, `p_neg`=0, `p_bcd`=20'h16384, `done` after edge 24.
- Pulse `start` again with new operands during `busy`: it is ignored, and the first result completes unchanged. Hold `start` high: the second operation is accepted on the edge after `done`.
- Assert `clrn` low mid-MUL and mid-BCD: all outputs are 0 immediately. After release, there is no `done` until a new `start`, and the new result is correct.
- Parameter sweep over WIDTH=4 and WIDTH=16 with random signed and unsigned operands:
  - `p` matches the reference product and `p_bcd` matches decimal |p|.
  - `done` timing matches k+2·WIDTH.

Source files
------------

// File: rtl/seq_multiplier_n_pkg.sv
// seq_multiplier_n_pkg
// Shared definitions for the sequential multiplier and its BCD converter:
//   - mult_state_t : controller states (IDLE=0, MUL=1, BCD=2)
//   - bcd_digits() : number of decimal digits needed for a 2*width-bit value.
//                    The display scanners use the same formula to size their
//                    digit buses.
package seq_multiplier_n_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    BCD  = 2'd2
  } mult_state_t;

  // log10(2) ~= 0.301, so a 2*width-bit value needs floor(2*width*0.301)+1 digits.
  function automatic int bcd_digits(input int width);
    return (2 * width * 301) / 1000 + 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_n_bin2bcd_seq.sv
// bin2bcd_seq
// Sequential double-dabble binary-to-BCD converter. It takes one cycle per
// input bit.
// Ports:
//   clk    : rising-edge clock
//   clrn   : asynchronous active-low reset
//   load   : capture 'bin' and start a conversion (takes priority over a
//            conversion already running)
//   bin    : binary magnitude to convert
//   busy   : a conversion is in progress
//   bcd    : value the BCD register takes at the next edge; on the cycle
//            where 'valid' is high this is the finished result
//   valid  : high during the final conversion cycle; the consumer registers
//            'bcd' on that edge
module bin2bcd_seq #(
  parameter int BITS   = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  load,
  input  logic [BITS-1:0]       bin,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid
);

  localparam int CW = $clog2(BITS + 1);

  logic [BITS-1:0]     bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;
  logic [CW-1:0]       cnt_q;

  // Add 3 to every digit that is 5 or more, so the following shift carries
  // the overflow into the next decimal digit.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The next binary bit enters at the bottom of the BCD register.
  assign bcd   = {adj[4*DIGITS-2:0], bin_q[BITS-1]};
  assign valid = busy && (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt_q <= CW'(BITS);
      busy  <= 1'b1;
    end else if (busy) begin
      bcd_q <= bcd;
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_multiplier_n.sv
// seq_multiplier_n
// Iterative shift-add multiplier. It supports unsigned and two's-complement
// operands and stops early once the remaining multiplier bits are zero. It
// then converts the product magnitude to BCD so the display path can show it
// directly.
// Ports:
//   clk, clrn : rising-edge clock, asynchronous active-low reset
//   start     : request; sampled only while idle (held high = back-to-back)
//   sign_mode : 0 = unsigned, 1 = two's-complement (sampled with start)
//   a, b      : multiplicand / multiplier (sampled with start)
//   busy      : operation in progress
//   done      : one-cycle pulse when p / p_neg / p_bcd update
//   p         : 2*WIDTH-bit product (two's-complement in signed mode)
//   p_neg     : product is negative
//   p_bcd     : BCD of |p|, least significant digit in [3:0]
module seq_multiplier_n
  import seq_multiplier_n_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            clrn,
  input  logic                            start,
  input  logic                            sign_mode,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  output logic                            busy,
  output logic                            done,
  output logic [2*WIDTH-1:0]              p,
  output logic                            p_neg,
  output logic [4*bcd_digits(WIDTH)-1:0]  p_bcd
);

  localparam int DIGITS = bcd_digits(WIDTH);
  localparam int PW     = 2 * WIDTH;

  mult_state_t state, state_next;

  logic [PW-1:0]       ma_q;
  logic [WIDTH-1:0]    mb_q;
  logic [PW-1:0]       acc_q;
  logic                neg_q;

  logic [WIDTH-1:0]    abs_a;
  logic [WIDTH-1:0]    abs_b;
  logic [PW-1:0]       acc_step;
  logic                mul_last;
  logic                conv_load;
  logic                conv_busy;
  logic                conv_valid;
  logic [4*DIGITS-1:0] conv_bcd;

  // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits in WIDTH unsigned bits, so the
  // magnitudes never overflow.
  assign abs_a = (sign_mode && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sign_mode && b[WIDTH-1]) ? -b : b;

  assign acc_step  = acc_q + (mb_q[0] ? ma_q : '0);
  // Early exit: this is the last step when no set bits remain above bit 0.
  assign mul_last  = (mb_q >> 1) == '0;
  assign conv_load = (state == MUL) && mul_last;

  bin2bcd_seq #(
    .BITS   (PW),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .clrn  (clrn),
    .load  (conv_load),
    .bin   (acc_step),
    .busy  (conv_busy),
    .bcd   (conv_bcd),
    .valid (conv_valid)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // If the converter ever stops without a valid cycle, fall back to IDLE
  // rather than wait forever. Nothing is published in that case.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = MUL;
      MUL:  if (mul_last) state_next = BCD;
      BCD: begin
        if (conv_valid) begin
          state_next = IDLE;
        end else if (!conv_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The accumulator always holds the magnitude. The sign is applied only
  // when publishing, so the converter sees |p| directly. A zero product is
  // never flagged negative.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ma_q  <= '0;
      mb_q  <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      p_neg <= 1'b0;
      p_bcd <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            ma_q  <= {{WIDTH{1'b0}}, abs_a};
            mb_q  <= abs_b;
            acc_q <= '0;
            neg_q <= sign_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        MUL: begin
          acc_q <= acc_step;
          ma_q  <= ma_q << 1;
          mb_q  <= mb_q >> 1;
        end
        BCD: begin
          if (conv_valid) begin
            p     <= neg_q ? -acc_q : acc_q;
            p_neg <= neg_q && (acc_q != '0);
            p_bcd <= conv_bcd;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_n.sv
// tb_seq_multiplier_n
// Scoreboard bench for seq_multiplier_n. The stimulus tasks push the expected
// result, including the cycle on which done must appear. Independent monitors
// pop and compare whenever a DUT raises done. WIDTH=8 uses hand-computed
// vectors. WIDTH=4 and WIDTH=16 use an arithmetic reference model.
module tb_seq_multiplier_n;

  typedef struct {
    logic [31:0] p;
    logic        pn;
    logic [39:0] bcd;
    int          cyc;
  } exp_t;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 8
  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, pn8;
  logic [15:0] p8;
  logic [19:0] bcd8;

  // WIDTH = 4
  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4, pn4;
  logic [7:0]  p4;
  logic [11:0] bcd4;

  // WIDTH = 16
  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, pn16;
  logic [31:0] p16;
  logic [39:0] bcd16;

  exp_t q8[$];
  exp_t q4[$];
  exp_t q16[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  seq_multiplier_n #(.WIDTH(8)) dut8 (
    .clk(clk), .clrn(clrn), .start(start8), .sign_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8), .p_neg(pn8), .p_bcd(bcd8)
  );

  seq_multiplier_n #(.WIDTH(4)) dut4 (
    .clk(clk), .clrn(clrn), .start(start4), .sign_mode(sm4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4), .p_neg(pn4), .p_bcd(bcd4)
  );

  seq_multiplier_n #(.WIDTH(16)) dut16 (
    .clk(clk), .clrn(clrn), .start(start16), .sign_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .p(p16), .p_neg(pn16), .p_bcd(bcd16)
  );

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic, decimal digits by repeated /10.
  function automatic exp_t modelExp(input int w, input bit sm, input logic [15:0] a,
                                    input logic [15:0] b, input int c0);
    exp_t   e;
    longint av, bv, prod, mag, mask, bm;
    int     k;
    av = longint'(a) & ((longint'(1) << w) - 1);
    bv = longint'(b) & ((longint'(1) << w) - 1);
    if (sm && a[w-1]) av = av - (longint'(1) << w);
    if (sm && b[w-1]) bv = bv - (longint'(1) << w);
    prod = av * bv;
    mag  = (prod < 0) ? -prod : prod;
    mask = (longint'(1) << (2 * w)) - 1;
    e.p  = 32'(prod & mask);
    e.pn = (prod < 0);
    e.bcd = '0;
    for (int i = 0; i < 10; i++) begin
      e.bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    bm = (bv < 0) ? -bv : bv;
    k  = 1;
    for (int i = 0; i < w; i++) if (bm[i]) k = i + 1;
    e.cyc = c0 + k + 2 * w;
    return e;
  endfunction

  // Monitors
  always @(negedge clk) begin
    exp_t e;
    if (clrn && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checkOutput("w8_unexpected_done", 40'(done8), 40'(0));
      end else begin
        e = q8.pop_front();
        checkOutput("w8_p", 40'(p8), 40'(e.p));
        checkOutput("w8_p_neg", 40'(pn8), 40'(e.pn));
        checkOutput("w8_p_bcd", 40'(bcd8), e.bcd);
        checkOutput("w8_done_cycle", 40'(cyc), 40'(e.cyc));
        checkOutput("w8_busy_at_done", 40'(busy8), 40'(0));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (clrn && done4 === 1'b1) begin
      if (q4.size() == 0) begin
        checkOutput("w4_unexpected_done", 40'(done4), 40'(0));
      end else begin
        e = q4.pop_front();
        checkOutput("w4_p", 40'(p4), 40'(e.p));
        checkOutput("w4_p_neg", 40'(pn4), 40'(e.pn));
        checkOutput("w4_p_bcd", 40'(bcd4), e.bcd);
        checkOutput("w4_done_cycle", 40'(cyc), 40'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (clrn && done16 === 1'b1) begin
      if (q16.size() == 0) begin
        checkOutput("w16_unexpected_done", 40'(done16), 40'(0));
      end else begin
        e = q16.pop_front();
        checkOutput("w16_p", 40'(p16), 40'(e.p));
        checkOutput("w16_p_neg", 40'(pn16), 40'(e.pn));
        checkOutput("w16_p_bcd", bcd16, e.bcd);
        checkOutput("w16_done_cycle", 40'(cyc), 40'(e.cyc));
      end
    end
  end

  // Issue one WIDTH=8 operation; k is the hand-computed MUL length.
  task automatic applyStimulus(input bit sm, input logic [7:0] a, input logic [7:0] b,
                               input int k, input logic [15:0] ep, input bit epn,
                               input logic [19:0] ebcd, input bit push);
    exp_t e;
    @(negedge clk);
    sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("w8_busy_after_accept", 40'(busy8), 40'(1));
    if (push) begin
      e.p = 32'(ep); e.pn = epn; e.bcd = 40'(ebcd); e.cyc = cyc + k + 16;
      q8.push_back(e);
    end
  endtask

  task automatic applySweep(input int w, input bit sm, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    if (w == 4) begin
      sm4 = sm; a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      checkOutput("w4_busy_after_accept", 40'(busy4), 40'(1));
      q4.push_back(modelExp(4, sm, a, b, cyc));
    end else begin
      sm16 = sm; a16 = a; b16 = b; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      checkOutput("w16_busy_after_accept", 40'(busy16), 40'(1));
      q16.push_back(modelExp(16, sm, a, b, cyc));
    end
  endtask

  task automatic waitDrain(input int maxc);
    int n = 0;
    while ((q8.size() + q4.size() + q16.size()) != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pending_results", 40'(q8.size() + q4.size() + q16.size()), 40'(0));
    q8.delete(); q4.delete(); q16.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_p"}, 40'(p8), 40'(0));
    checkOutput({tag, "_p_neg"}, 40'(pn8), 40'(0));
    checkOutput({tag, "_p_bcd"}, 40'(bcd8), 40'(0));
    checkOutput({tag, "_done"}, 40'(done8), 40'(0));
    checkOutput({tag, "_busy"}, 40'(busy8), 40'(0));
  endtask

  initial begin
    exp_t e;
    int   c0;
    int   n;

    repeat (2) @(negedge clk);
    checkAllZero("reset");
    clrn = 1'b1;
    @(negedge clk);

    // Directed WIDTH=8 vectors
    applyStimulus(0, 8'd12,  8'd13,  4, 16'd156,  0, 20'h00156, 1); waitDrain(100);
    applyStimulus(0, 8'd255, 8'd255, 8, 16'hFE01, 0, 20'h65025, 1); waitDrain(100);
    applyStimulus(0, 8'd200, 8'd0,   1, 16'd0,    0, 20'h00000, 1); waitDrain(100);
    applyStimulus(0, 8'h80,  8'hFF,  8, 16'h7F80, 0, 20'h32640, 1); waitDrain(100);
    applyStimulus(1, 8'hFD,  8'd5,   3, 16'hFFF1, 1, 20'h00015, 1); waitDrain(100);
    applyStimulus(1, 8'h80,  8'h80,  8, 16'h4000, 0, 20'h16384, 1); waitDrain(100);
    applyStimulus(1, 8'd7,   8'hFA,  3, 16'hFFD6, 1, 20'h00042, 1); waitDrain(100);
    applyStimulus(1, 8'h7F,  8'h80,  8, 16'hC080, 1, 20'h16256, 1); waitDrain(100);

    // A start pulse while busy must be ignored.
    applyStimulus(0, 8'd12, 8'd13, 4, 16'd156, 0, 20'h00156, 1);
    repeat (3) @(negedge clk);
    sm8 = 1'b1; a8 = 8'd7; b8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    waitDrain(100);

    // Holding start high gives back-to-back operations.
    @(negedge clk);
    sm8 = 1'b0; a8 = 8'd12; b8 = 8'd13; start8 = 1'b1;
    @(negedge clk);
    checkOutput("b2b_busy_first", 40'(busy8), 40'(1));
    c0 = cyc;
    a8 = 8'd3; b8 = 8'd2;
    e.p = 32'd156; e.pn = 1'b0; e.bcd = 40'h00156; e.cyc = c0 + 20; q8.push_back(e);
    e.p = 32'd6;   e.pn = 1'b0; e.bcd = 40'h00006; e.cyc = c0 + 39; q8.push_back(e);
    n = 0;
    while (done8 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b2b_first_done_seen", 40'(done8), 40'(1));
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("b2b_busy_second", 40'(busy8), 40'(1));
    waitDrain(100);

    // Reset in the middle of MUL
    applyStimulus(0, 8'd255, 8'd255, 8, 16'd0, 0, 20'h0, 0);
    repeat (2) @(negedge clk);
    clrn = 1'b0;
    #1;
    checkAllZero("rst_mul");
    @(negedge clk);
    clrn = 1'b1;
    repeat (30) @(negedge clk);

    // Reset in the middle of BCD, after a published result
    applyStimulus(1, 8'h80, 8'h80, 8, 16'h4000, 0, 20'h16384, 1); waitDrain(100);
    applyStimulus(0, 8'd255, 8'd255, 8, 16'd0, 0, 20'h0, 0);
    repeat (12) @(negedge clk);
    clrn = 1'b0;
    #1;
    checkAllZero("rst_bcd");
    @(negedge clk);
    clrn = 1'b1;
    repeat (30) @(negedge clk);
    applyStimulus(0, 8'd25, 8'd4, 3, 16'd100, 0, 20'h00100, 1); waitDrain(100);

    // Other widths
    applySweep(4, 0, 16'd3,  16'd5);   waitDrain(100);
    applySweep(4, 0, 16'd15, 16'd15);  waitDrain(100);
    applySweep(4, 1, 16'h8,  16'h8);   waitDrain(100);
    applySweep(4, 1, 16'h7,  16'hD);   waitDrain(100);
    applySweep(4, 0, 16'd9,  16'd0);   waitDrain(100);
    applySweep(16, 0, 16'hFFFF, 16'hFFFF); waitDrain(200);
    applySweep(16, 1, 16'h8000, 16'h8000); waitDrain(200);
    applySweep(16, 1, 16'hFB2E, 16'd5678); waitDrain(200);
    applySweep(16, 0, 16'd40000, 16'd3);   waitDrain(200);
    applySweep(16, 1, 16'hFFFF, 16'h7FFF); waitDrain(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
